// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - decode-side valid/ready bundle of the fetch queue
interface fetch_queue_if #(
  parameter int ARCHITECTURE = 32
);
  logic                    dec_valid;
  logic                    dec_ready;
  logic [31:0]             dec_instr;
  logic [ARCHITECTURE-1:0] dec_pc;
  logic [31:0]             dec_pcincr;
  logic                    dec_misalign;

  modport master (
    output dec_valid, dec_instr, dec_pc, dec_pcincr, dec_misalign,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_instr, dec_pc, dec_pcincr, dec_misalign,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: F1 capture, tagged queue to decode, drop/replay on overflow
module fetch_queue #(
  parameter int DEPTH        = 4,
  parameter int ARCHITECTURE = 32
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [ARCHITECTURE-1:0] pc_i,
  input  logic [31:0]             pc_incr_i,
  input  logic                    flush_i,
  output logic [ARCHITECTURE-1:0] imem_addr_o,
  input  logic [31:0]             imem_rdata_i,
  fetch_queue_if.master           dec_if,
  output logic                    replay_req_o,
  output logic [ARCHITECTURE-1:0] replay_pc_o,
  input  logic                    replay_ack_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, DROP, REPLAY, RESUME} state_e;

  state_e                  state_q, state_d;
  logic                    f1_valid_q, f1_valid_d;
  logic [ARCHITECTURE-1:0] f1_pc_q;
  logic [31:0]             f1_pcincr_q;
  logic                    f1_mis_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    replay_req_q, replay_req_d;
  logic [ARCHITECTURE-1:0] replay_pc_q, replay_pc_d;

  logic [31:0]             instr_mem  [DEPTH];
  logic [ARCHITECTURE-1:0] pc_mem     [DEPTH];
  logic [31:0]             pcincr_mem [DEPTH];
  logic                    mis_mem    [DEPTH];

  logic head_valid, pop, space, push, overflow;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & dec_if.dec_ready;
  // A full queue still accepts the F1 return when decode frees a slot in the same cycle.
  assign space      = (count_q < FULL) | pop;
  assign push       = f1_valid_q & space & ~flush_i;
  assign overflow   = (state_q == RUN) & f1_valid_q & ~space & ~flush_i;

  always_comb begin
    state_d      = state_q;
    f1_valid_d   = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    replay_req_d = replay_req_q;
    replay_pc_d  = replay_pc_q;
    if (flush_i) begin
      state_d      = RUN;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      replay_req_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      case (state_q)
        RUN: begin
          if (overflow) begin
            replay_pc_d = f1_pc_q;
            state_d     = DROP;
          end else begin
            f1_valid_d = 1'b1;
          end
        end
        DROP: begin
          if (count_d < FULL) begin
            state_d      = REPLAY;
            replay_req_d = 1'b1;
          end
        end
        REPLAY: begin
          // The fetch issued alongside the ack is wrong-path; f1_valid stays low.
          if (replay_ack_i) begin
            state_d      = RESUME;
            replay_req_d = 1'b0;
          end
        end
        RESUME: begin
          f1_valid_d = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= RUN;
      f1_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      replay_req_q <= 1'b0;
      replay_pc_q  <= '0;
    end else begin
      state_q      <= state_d;
      f1_valid_q   <= f1_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      replay_req_q <= replay_req_d;
      replay_pc_q  <= replay_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    f1_pc_q     <= pc_i;
    f1_pcincr_q <= pc_incr_i;
    f1_mis_q    <= (pc_i[1:0] != 2'b00);
    if (push && !RESET) begin
      instr_mem[wr_ptr_q]  <= imem_rdata_i;
      pc_mem[wr_ptr_q]     <= f1_pc_q;
      pcincr_mem[wr_ptr_q] <= f1_pcincr_q;
      mis_mem[wr_ptr_q]    <= f1_mis_q;
    end
  end

  assign imem_addr_o         = pc_i;
  assign dec_if.dec_valid    = head_valid;
  assign dec_if.dec_instr    = head_valid ? instr_mem[rd_ptr_q]  : '0;
  assign dec_if.dec_pc       = head_valid ? pc_mem[rd_ptr_q]     : '0;
  assign dec_if.dec_pcincr   = head_valid ? pcincr_mem[rd_ptr_q] : '0;
  assign dec_if.dec_misalign = head_valid & mis_mem[rd_ptr_q];
  assign replay_req_o        = replay_req_q;
  assign replay_pc_o         = replay_pc_q;
  assign count_o             = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench: decode must see each program address exactly once, in order
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int ARCH  = 32;

  logic        clk = 1'b0;
  logic        RESET;
  logic [31:0] pc_i, pc_incr_i, imem_addr_o, imem_rdata_i, replay_pc_o;
  logic        flush_i, replay_req_o, replay_ack_i;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  fetch_queue_if #(.ARCHITECTURE(ARCH)) dec_bus ();

  fetch_queue #(.DEPTH(DEPTH), .ARCHITECTURE(ARCH)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .pc_i         (pc_i),
    .pc_incr_i    (pc_incr_i),
    .flush_i      (flush_i),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .dec_if       (dec_bus),
    .replay_req_o (replay_req_o),
    .replay_pc_o  (replay_pc_o),
    .replay_ack_i (replay_ack_i),
    .count_o      (count_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcincr;
    logic        mis;
  } entry_t;

  entry_t      exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] seg_hi;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head must be the next unique program address.
  always @(negedge clk) begin : monitor
    entry_t e;
    check("imem_addr", 128'(imem_addr_o), 128'(pc_i));
    if (dec_bus.dec_valid && dec_bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dec_unexpected: got pc %h, expected no entry", dec_bus.dec_pc);
      end else begin
        e = exp_q.pop_front();
        check("dec_entry",
              128'({dec_bus.dec_pc, dec_bus.dec_instr, dec_bus.dec_pcincr, dec_bus.dec_misalign}),
              128'(e));
      end
    end
  end

  // One cycle of the PC stage and instruction memory, driven from posedge+1 to posedge+1.
  task automatic tick(input bit rst, input bit rdy, input bit fl, input logic [31:0] tgt, input bit ack);
    logic [31:0] nxt;
    RESET              = rst;
    dec_bus.dec_ready  = rdy;
    flush_i            = fl;
    replay_ack_i       = ack;
    if (!rst && pc_i == seg_hi) begin
      exp_q.push_back({pc_i, instr_of(pc_i), pc_i + 32'd4, (pc_i[1:0] != 2'b00)});
      seg_hi = pc_i + 32'd4;
    end
    @(negedge clk);
    #1;
    if (rst || fl) exp_q.delete();
    @(posedge clk);
    #1;
    imem_rdata_i = instr_of(pc_i);
    nxt          = fl ? tgt : (ack ? replay_pc_o : pc_i + 32'd4);
    pc_i         = nxt;
    pc_incr_i    = nxt + 32'd4;
    if (rst || fl) seg_hi = nxt;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic restart(input logic [31:0] start, input bit rdy);
    tick(1'b1, rdy, 1'b0, 32'h0, 1'b0);
    tick(1'b1, rdy, 1'b0, 32'h0, 1'b0);
    pc_i      = start;
    pc_incr_i = start + 32'd4;
    seg_hi    = start;
  endtask

  initial begin
    bit          rst, fl, rdy, ack;
    logic [31:0] tgt;
    RESET = 1'b1; pc_i = 32'h0; pc_incr_i = 32'h4; flush_i = 1'b0; replay_ack_i = 1'b0;
    imem_rdata_i = 32'h0; dec_bus.dec_ready = 1'b0; seg_hi = 32'h0;
    @(posedge clk);
    #1;

    // Reset state, then streaming with decode always ready
    restart(32'h0, 1'b1);
    check("rst_count", 128'(count_o), 128'(0));
    check("rst_valid", 128'(dec_bus.dec_valid), 128'(0));
    check("rst_dec_pc", 128'(dec_bus.dec_pc), 128'(0));
    check("rst_replay_req", 128'(replay_req_o), 128'(0));
    check("rst_replay_pc", 128'(replay_pc_o), 128'(0));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("lat_valid_t1", 128'(dec_bus.dec_valid), 128'(0));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("lat_valid_t2", 128'(dec_bus.dec_valid), 128'(1));
    check("lat_pc", 128'(dec_bus.dec_pc), 128'(32'h0));
    check("lat_pcincr", 128'(dec_bus.dec_pcincr), 128'(32'h4));
    run(6, 1'b1);
    check("stream_count", 128'(count_o), 128'(1));

    // Overflow drop, replay request after one pop, replay resumes at 0x10
    restart(32'h0, 1'b0);
    run(6, 1'b0);
    check("ovf_count", 128'(count_o), 128'(4));
    check("ovf_replay_pc", 128'(replay_pc_o), 128'(32'h10));
    check("ovf_req_low", 128'(replay_req_o), 128'(0));
    run(3, 1'b0);
    check("drop_req_low", 128'(replay_req_o), 128'(0));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("drop_req_high", 128'(replay_req_o), 128'(1));
    check("drop_count", 128'(count_o), 128'(3));
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("ack_req_low", 128'(replay_req_o), 128'(0));
    check("ack_pc_i", 128'(pc_i), 128'(32'h10));
    run(12, 1'b1);

    // Flush with three queued entries and one in flight
    restart(32'h0, 1'b0);
    run(4, 1'b0);
    check("pre_flush_count", 128'(count_o), 128'(3));
    tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_valid", 128'(dec_bus.dec_valid), 128'(0));
    run(2, 1'b1);
    check("flush_first_pc", 128'(dec_bus.dec_pc), 128'(32'h200));
    run(4, 1'b1);

    // Flush together with replay ack while in REPLAY
    restart(32'h0, 1'b0);
    run(6, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rep_req_high", 128'(replay_req_o), 128'(1));
    tick(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    check("fa_req_low", 128'(replay_req_o), 128'(0));
    check("fa_count", 128'(count_o), 128'(0));
    run(2, 1'b1);
    check("fa_first_pc", 128'(dec_bus.dec_pc), 128'(32'h300));
    run(6, 1'b1);

    // Full queue with simultaneous pop and push: no drop, order kept across wrap
    restart(32'h0, 1'b0);
    run(5, 1'b0);
    check("full_count", 128'(count_o), 128'(4));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("full_pp_count", 128'(count_o), 128'(4));
    run(6, 1'b1);
    check("full_pp_count2", 128'(count_o), 128'(4));
    check("full_pp_req", 128'(replay_req_o), 128'(0));

    // Misaligned supervisor PC, then reset with a full queue
    restart(32'h0, 1'b1);
    run(3, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 32'h8000_0006, 1'b0);
    run(2, 1'b1);
    check("mis_flag", 128'(dec_bus.dec_misalign), 128'(1));
    check("mis_pc", 128'(dec_bus.dec_pc), 128'(32'h8000_0006));
    check("mis_pcincr", 128'(dec_bus.dec_pcincr), 128'(32'h8000_000A));
    check("mis_instr", 128'(dec_bus.dec_instr), 128'(instr_of(32'h8000_0006)));
    run(6, 1'b0);
    check("sup_count", 128'(count_o), 128'(4));
    check("sup_replay_pc", 128'(replay_pc_o), 128'(32'h8000_0016));
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mrst_count", 128'(count_o), 128'(0));
    check("mrst_outs",
          128'({dec_bus.dec_valid, dec_bus.dec_instr, dec_bus.dec_pc, dec_bus.dec_pcincr,
                dec_bus.dec_misalign, replay_req_o, replay_pc_o}),
          128'(0));

    // Randomized traffic
    restart(32'h1000, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      fl  = ($urandom_range(0, 49) == 0);
      tgt = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      rdy = ($urandom_range(0, 9) < 6);
      ack = replay_req_o && ($urandom_range(0, 2) == 0);
      tick(rst, rdy, fl, tgt, ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it issues pc_o as the instruction-memory address and captures the synchronous read data one cycle later.
- It tags each instruction with its PC and PC+4, then buffers it in a DEPTH-entry queue that feeds decode over a valid/ready handshake.
- Because the PC advances every cycle without an enable, overflow is handled by dropping the fetch and requesting a replay redirect through the JT path (PCSEL=010).

Parameters:
DEPTH, 4, queue entries; power of two, >=2
ARCHITECTURE, 32, width of address/instruction datapath

Ports:
clk  input  1  global clock
RESET  input  1  synchronous, active-high reset
pc_i  input  ARCHITECTURE  current PC (pc_o of PC stage)
pc_incr_i  input  32  PC+4 (PcIncr of PC stage)
flush_i  input  1  redirect this cycle (PCSEL!=000, IRQ taken, or RESET path); kills wrong-path fetches
imem_addr_o  output  ARCHITECTURE  instruction memory address, equal to pc_i (combinational)
imem_rdata_i  input  32  instruction data, valid the cycle after the address
dec_valid_o  output  1  queue head valid
dec_ready_i  input  1  decode accepts head
dec_instr_o  output  32  head instruction
dec_pc_o  output  ARCHITECTURE  head PC (bit 31 = supervisor)
dec_pcincr_o  output  32  head PC+4
dec_misalign_o  output  1  head fetched from pc[1:0]!=0
replay_req_o  output  1  request PC redirect to replay_pc_o
replay_pc_o  output  ARCHITECTURE  address of first dropped fetch
replay_ack_i  input  1  control applied the replay (PCSEL=010, JT=replay_pc_o) this cycle
count_o  output  log2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (RESET=1 at posedge):
  - queue empty; count_o=0; dec_valid_o=0; all dec_* data outputs=0.
  - f1_valid=0; state=RUN; replay_req_o=0; replay_pc_o=0.
  - Same result when reset is asserted mid-operation.
- F1 register:
  - At each edge, capture f1_pc=pc_i, f1_pcincr=pc_incr_i and f1_mis=(pc_i[1:0]!=0).
  - f1_valid <= (state==RUN) & ~flush_i & ~replay_ack_i & ~RESET.
  - In state RESUME, f1_valid <= 1 and state goes to RUN.
- Push, in the cycle after issue: when f1_valid, form the entry {imem_rdata_i, f1_pc, f1_pcincr, f1_mis}.
  - The entry is pushed if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Pop: when dec_valid_o & dec_ready_i, the head is removed at the edge.
- Latency: address issued in cycle t, data pushed at end of t+1, dec_valid_o high in t+2 at the earliest. No bypass.
- Pointers wrap modulo DEPTH. count_o is updated by +1 (push only), -1 (pop only) or 0 (both or neither).
- Head outputs hold stable while dec_valid_o & ~dec_ready_i.
- Overflow (RUN state, f1_valid and push not allowed):
  - Entry is dropped; replay_pc_o <= f1_pc; state -> DROP.
  - All later F1 returns are discarded; f1_valid is forced 0.
- DROP: when count<DEPTH, state -> REPLAY and replay_req_o=1 (registered).
- REPLAY:
  - replay_req_o stays 1 until replay_ack_i.
  - On ack: replay_req_o -> 0, state -> RESUME; the fetch in the ack cycle is killed.
  - The next cycle's pc_i equals replay_pc_o, and that fetch is valid.
- flush_i:
  - Empties the queue, count_o=0, kills f1_valid, state -> RUN, replay_req_o -> 0.
  - Priority: RESET > flush_i > replay_ack_i > push/pop.
  - A pop in the flush cycle is still considered taken by decode.
- replay_ack_i outside REPLAY is ignored.
- Supervisor bit pc[31] is carried unchanged into dec_pc_o and replay_pc_o.
- Misaligned PC: data is queued normally with dec_misalign_o=1; decode raises the illegal-op.

Test Plan:
- Reset, then pc_i=0,4,8… with dec_ready_i=1 and imem returning pc-derived data -> dec_valid_o first high 2 cycles after reset release; dec_pc_o=0,4,8 in order; dec_pcincr_o=4,8,C; count_o settles at 1.
- dec_ready_i=0 from start with DEPTH=4 -> count_o reaches 4; fetch of 0x10 is dropped; replay_pc_o=0x10; replay_req_o stays 0 until dec_ready_i pulses once, then goes 1 the following cycle; ack -> next dec entry after 0x0C is 0x10, with no duplicates or holes.
- Queue holding 3 entries plus an in-flight fetch, flush_i=1 with the next pc_i=0x200 -> count_o=0, the in-flight fetch is discarded, and the first dec_pc_o after the flush is 0x200.
- Flush asserted in REPLAY state with replay_ack_i=1 in the same cycle -> replay_req_o=0, state RUN, queue empty, and no resume fetch of replay_pc_o.
- count_o=4 with dec_ready_i=1 and a valid push in the same cycle -> no drop; count_o stays 4; order is preserved across pointer wrap.
- pc_i=0x80000006 -> entry carries dec_misalign_o=1, dec_pc_o=0x80000006 (supervisor bit kept); RESET asserted while the queue is full -> all outputs 0 the next cycle.
